axi4_default_slave: RTL and testbench

AXI4 responder that terminates every transaction the address decoder cannot route: unmapped addresses or accesses denied by the slave-permission matrix. It sits on the interconnect's error port, opposite the decoder's `access_error` / empty `slave_select` outcome, and answers each burst with a protocol-complete DECERR response so masters never hang. Write and read paths are independent engines running concurrently.

---
 rtl/axi4_default_slave_pkg.sv | 8 +
 rtl/axi4_default_slave_rd.sv | 59 +++++
 rtl/axi4_default_slave.sv | 118 +++++++++++
 tb/tb_axi4_default_slave.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/axi4_default_slave_pkg.sv
// axi4_default_slave_pkg: shared response codes, FSM state types and log counter width
package axi4_default_slave_pkg;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_DECERR = 2'b11;
   localparam int CNT_WIDTH = 16;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_DATA} r_state_t;
endpackage

// File: rtl/axi4_default_slave_rd.sv
// axi4_default_slave_rd: read engine answering every AR burst with arlen+1 DECERR beats
module axi4_default_slave_rd
   import axi4_default_slave_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 4
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic [ID_WIDTH-1:0]   arid,
   input  logic [7:0]            arlen,
   input  logic                  arvalid,
   output logic                  arready,
   output logic [ID_WIDTH-1:0]   rid,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic [1:0]            rresp,
   output logic                  rlast,
   output logic                  rvalid,
   input  logic                  rready
);
   r_state_t r_state, r_next;
   logic [7:0] cnt, cnt_n;
   logic [ID_WIDTH-1:0] rid_n;
   logic ar_hs, r_hs, arready_n, rvalid_n, rlast_n;

   assign rdata = '0;
   assign rresp = RESP_DECERR;

   // next state, beat counter and next registered outputs
   always_comb begin
      ar_hs     = arvalid && arready;
      r_hs      = rvalid && rready;
      r_next    = ar_hs ? R_DATA : (r_hs && rlast) ? R_IDLE : r_state;
      cnt_n     = ar_hs ? arlen : r_hs ? cnt - 8'd1 : cnt;
      rid_n     = ar_hs ? arid : rid;
      arready_n = r_next == R_IDLE;
      rvalid_n  = r_next == R_DATA;
      rlast_n   = rvalid_n && cnt_n == 8'd0;
   end

   // state and output registers; readies stay low through reset
   always_ff @(posedge aclk) begin
      if (areset) begin
         r_state <= R_IDLE;
         cnt     <= '0;
         rid     <= '0;
         arready <= 1'b0;
         rvalid  <= 1'b0;
         rlast   <= 1'b0;
      end else begin
         r_state <= r_next;
         cnt     <= cnt_n;
         rid     <= rid_n;
         arready <= arready_n;
         rvalid  <= rvalid_n;
         rlast   <= rlast_n;
      end
   end
endmodule

// File: rtl/axi4_default_slave.sv
// axi4_default_slave: DECERR responder for unroutable AXI4 bursts; AXI4_DEFAULT_SLAVE_ERR_LOG_EN adds error logging
module axi4_default_slave
   import axi4_default_slave_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 4
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic [ID_WIDTH-1:0]   awid,
   input  logic [ADDR_WIDTH-1:0] awaddr,
   input  logic [7:0]            awlen,
   input  logic                  awvalid,
   output logic                  awready,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  wlast,
   input  logic                  wvalid,
   output logic                  wready,
   output logic [ID_WIDTH-1:0]   bid,
   output logic [1:0]            bresp,
   output logic                  bvalid,
   input  logic                  bready,
   input  logic [ID_WIDTH-1:0]   arid,
   input  logic [ADDR_WIDTH-1:0] araddr,
   input  logic [7:0]            arlen,
   input  logic                  arvalid,
   output logic                  arready,
   output logic [ID_WIDTH-1:0]   rid,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic [1:0]            rresp,
   output logic                  rlast,
   output logic                  rvalid,
`ifdef AXI4_DEFAULT_SLAVE_ERR_LOG_EN
   output logic [CNT_WIDTH-1:0]  wr_err_cnt,
   output logic [CNT_WIDTH-1:0]  rd_err_cnt,
   output logic [ADDR_WIDTH-1:0] last_err_addr,
   output logic                  last_err_is_wr,
`endif
   input  logic                  rready
);
   w_state_t w_state, w_next;
   logic [ID_WIDTH-1:0] bid_n;
   logic aw_hs, awready_n, wready_n, bvalid_n;

   assign bresp = RESP_DECERR;

   // write next state; data beats are swallowed until wlast
   always_comb begin
      aw_hs     = awvalid && awready;
      w_next    = aw_hs ? W_DATA :
                  (wvalid && wready && wlast) ? W_RESP :
                  (bvalid && bready) ? W_IDLE : w_state;
      bid_n     = aw_hs ? awid : bid;
      awready_n = w_next == W_IDLE;
      wready_n  = w_next == W_DATA;
      bvalid_n  = w_next == W_RESP;
   end

   // write state and output registers; readies stay low through reset
   always_ff @(posedge aclk) begin
      if (areset) begin
         w_state <= W_IDLE;
         bid     <= '0;
         awready <= 1'b0;
         wready  <= 1'b0;
         bvalid  <= 1'b0;
      end else begin
         w_state <= w_next;
         bid     <= bid_n;
         awready <= awready_n;
         wready  <= wready_n;
         bvalid  <= bvalid_n;
      end
   end

   axi4_default_slave_rd #(.DATA_WIDTH(DATA_WIDTH), .ID_WIDTH(ID_WIDTH)) u_rd (
      .aclk    (aclk),
      .areset  (areset),
      .arid    (arid),
      .arlen   (arlen),
      .arvalid (arvalid),
      .arready (arready),
      .rid     (rid),
      .rdata   (rdata),
      .rresp   (rresp),
      .rlast   (rlast),
      .rvalid  (rvalid),
      .rready  (rready)
   );

`ifdef AXI4_DEFAULT_SLAVE_ERR_LOG_EN
   logic ar_hs;
   logic unused_in;
   assign ar_hs = arvalid && arready;
   assign unused_in = ^{wdata, awlen};

   // saturating handshake counters and most recent failing address, write wins ties
   always_ff @(posedge aclk) begin
      if (areset) begin
         wr_err_cnt     <= '0;
         rd_err_cnt     <= '0;
         last_err_addr  <= '0;
         last_err_is_wr <= 1'b0;
      end else begin
         if (aw_hs && wr_err_cnt != '1) wr_err_cnt <= wr_err_cnt + 1'b1;
         if (ar_hs && rd_err_cnt != '1) rd_err_cnt <= rd_err_cnt + 1'b1;
         if (aw_hs || ar_hs) begin
            last_err_addr  <= aw_hs ? awaddr : araddr;
            last_err_is_wr <= aw_hs;
         end
      end
   end
`else
   logic unused_in;
   assign unused_in = ^{wdata, awlen, awaddr, araddr};
`endif
endmodule

// File: tb/tb_axi4_default_slave.sv
// tb_axi4_default_slave: directed stimulus with queued expected B/R responses checked by a monitor
module tb_axi4_default_slave;
   logic        aclk = 1'b0;
   logic        areset = 1'b1;
   logic [3:0]  awid = '0, arid = '0, bid, rid;
   logic [31:0] awaddr = '0, araddr = '0, wdata = '0, rdata;
   logic [7:0]  awlen = '0, arlen = '0;
   logic        awvalid = 1'b0, wlast = 1'b0, wvalid = 1'b0, bready = 1'b0;
   logic        arvalid = 1'b0, rready = 1'b0;
   logic        awready, wready, bvalid, arready, rlast, rvalid;
   logic [1:0]  bresp, rresp;
`ifdef AXI4_DEFAULT_SLAVE_ERR_LOG_EN
   logic [15:0] wr_err_cnt, rd_err_cnt;
   logic [31:0] last_err_addr;
   logic        last_err_is_wr;
`endif

   typedef struct {logic [3:0] id; logic last;} exp_t;
   exp_t b_q[$], r_q[$];
   int total = 0, bad = 0;
   bit r_stall = 0, b_stall = 0;
   logic [63:0] r_snap, b_snap;

   always #5 aclk = ~aclk;

   axi4_default_slave dut (
      .aclk(aclk), .areset(areset),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
`ifdef AXI4_DEFAULT_SLAVE_ERR_LOG_EN
      .wr_err_cnt(wr_err_cnt), .rd_err_cnt(rd_err_cnt),
      .last_err_addr(last_err_addr), .last_err_is_wr(last_err_is_wr),
`endif
      .rready(rready)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge aclk);
      #1;
   endtask

   // monitor: pop and compare on every B/R handshake, and check stability while stalled
   always @(negedge aclk) begin
      exp_t e;
      if (areset) begin
         r_stall = 0;
         b_stall = 0;
      end else begin
         if (r_stall) chk("r_stable", {23'd0, rvalid, rid, rlast, rresp, rdata}, r_snap);
         if (b_stall) chk("b_stable", {57'd0, bvalid, bid, bresp}, b_snap);
         if (rvalid && rready) begin
            if (r_q.size() == 0) chk("r_unexpected", 1, 0);
            else begin
               e = r_q.pop_front();
               chk("rid", rid, e.id);
               chk("rlast", rlast, e.last);
               chk("rresp", rresp, 2'b11);
               chk("rdata", rdata, 0);
            end
         end
         if (bvalid && bready) begin
            if (b_q.size() == 0) chk("b_unexpected", 1, 0);
            else begin
               e = b_q.pop_front();
               chk("bid", bid, e.id);
               chk("bresp", bresp, 2'b11);
            end
         end
         r_stall = rvalid && !rready;
         r_snap  = {23'd0, rvalid, rid, rlast, rresp, rdata};
         b_stall = bvalid && !bready;
         b_snap  = {57'd0, bvalid, bid, bresp};
      end
   end

   task automatic do_reset;
      areset = 1'b1;
      tick;
      tick;
      areset = 1'b0;
      tick;
      chk("ready_after_reset", {awready, arready}, 2'b11);
   endtask

   task automatic wr(input logic [3:0] id, input logic [31:0] addr, input int beats);
      int n = 0;
      awid = id; awaddr = addr; awlen = 8'(beats - 1); awvalid = 1'b1;
      while (!awready && n < 50) begin tick; n++; end
      if (n == 50) chk("aw_timeout", 0, 1);
      tick;
      awvalid = 1'b0;
      chk("aw_then_wready", {awready, wready}, 2'b01);
      b_q.push_back('{id, 1'b1});
      bready = 1'b1;
      for (int i = 0; i < beats; i++) begin
         wvalid = 1'b1; wlast = (i == beats - 1); wdata = 32'(i);
         tick;
      end
      wvalid = 1'b0; wlast = 1'b0;
      chk("bvalid_after_last", {wready, bvalid}, 2'b01);
      tick;
      chk("aw_after_b", {awready, bvalid}, 2'b10);
   endtask

   task automatic rd(input logic [3:0] id, input logic [31:0] addr, input int len, input bit toggle);
      int n = 0, beats = 0, cyc = 0;
      arid = id; araddr = addr; arlen = 8'(len); arvalid = 1'b1;
      while (!arready && n < 50) begin tick; n++; end
      if (n == 50) chk("ar_timeout", 0, 1);
      tick;
      arvalid = 1'b0;
      for (int i = 0; i <= len; i++) r_q.push_back('{id, (i == len)});
      chk("r_first", {arready, rvalid}, 2'b01);
      rready = 1'b1;
      while (beats < len + 1 && cyc < 2000) begin
         if (rvalid && rready) beats++;
         tick;
         cyc++;
         if (toggle) rready = ~rready;
      end
      rready = 1'b0;
      chk("r_beats", beats, len + 1);
      chk("ar_after_last", {arready, rvalid}, 2'b10);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      tick;
      tick;
      chk("reset_readies", {awready, wready, arready}, 0);
      chk("reset_valids", {bvalid, rvalid, rlast}, 0);
      chk("reset_ids", {bid, rid}, 0);
      chk("reset_resp_data", {bresp, rresp, rdata}, {4'hF, 32'd0});
      areset = 1'b0;
      tick;
      chk("ready_after_reset", {awready, arready}, 2'b11);

      wvalid = 1'b1;
      tick;
      chk("w_idle_no_wready", {awready, wready}, 2'b10);
      wvalid = 1'b0;

      wr(4'h5, 32'h100, 4);
      rd(4'hA, 32'h200, 0, 0);
      rd(4'h2, 32'h300, 255, 1);

      awid = 4'h3; awlen = 8'd0; awvalid = 1'b1;
      arid = 4'h6; arlen = 8'd2; arvalid = 1'b1;
      bready = 1'b0;
      tick;
      awvalid = 1'b0; arvalid = 1'b0;
      chk("both_accepted", {awready, arready, wready, rvalid}, 4'b0011);
      b_q.push_back('{4'h3, 1'b1});
      for (int i = 0; i < 3; i++) r_q.push_back('{4'h6, (i == 2)});
      wvalid = 1'b1; wlast = 1'b1; rready = 1'b1;
      tick;
      wvalid = 1'b0; wlast = 1'b0;
      repeat (4) tick;
      chk("read_done_b_held", {arready, rvalid, bvalid}, 3'b101);
      rready = 1'b0;
      bready = 1'b1;
      tick;
      chk("aw_after_late_b", {awready, bvalid}, 2'b10);

      arid = 4'h7; arlen = 8'd3; arvalid = 1'b1;
      tick;
      arvalid = 1'b0;
      for (int i = 0; i < 4; i++) r_q.push_back('{4'h7, (i == 3)});
      rready = 1'b1;
      tick;
      areset = 1'b1; rready = 1'b0;
      tick;
      chk("reset_mid_burst", {rvalid, rlast, arready, awready}, 0);
      r_q.delete();
      areset = 1'b0;
      tick;
      chk("arready_after_mid_reset", {arready, awready}, 2'b11);

`ifdef AXI4_DEFAULT_SLAVE_ERR_LOG_EN
      do_reset;
      chk("log_reset", {wr_err_cnt, rd_err_cnt, last_err_addr, last_err_is_wr}, 0);
      wr(4'h1, 32'h0000_1000, 1);
      chk("log_wr1", {wr_err_cnt, last_err_addr, last_err_is_wr}, {16'd1, 32'h0000_1000, 1'b1});
      wr(4'h2, 32'h0000_2000, 2);
      wr(4'h3, 32'h0000_3000, 1);
      rd(4'h4, 32'h8000_0010, 1, 0);
      chk("log_wr_cnt", wr_err_cnt, 3);
      chk("log_rd_cnt", rd_err_cnt, 1);
      chk("log_addr", last_err_addr, 32'h8000_0010);
      chk("log_is_wr", last_err_is_wr, 0);
`endif

      repeat (3) tick;
      chk("b_queue_empty", b_q.size(), 0);
      chk("r_queue_empty", r_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
